// File: rtl/alu_share_arbiter_if.sv
// Two-requester ALU request bus plus a single response channel.
// master = requesters and consumer side, slave = the arbiter/ALU.
interface alu_share_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [2:0]  req0_op;
  logic        req0_alu32;
  logic [63:0] req0_a;
  logic [63:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [2:0]  req1_op;
  logic        req1_alu32;
  logic [63:0] req1_a;
  logic [63:0] req1_b;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic [63:0] resp_data;

  modport master (
    output req0_valid, req0_op, req0_alu32, req0_a, req0_b,
    output req1_valid, req1_op, req1_alu32, req1_a, req1_b,
    output resp_ready,
    input  req0_ready, req1_ready, resp_valid, resp_id, resp_data
  );

  modport slave (
    input  req0_valid, req0_op, req0_alu32, req0_a, req0_b,
    input  req1_valid, req1_op, req1_alu32, req1_a, req1_b,
    input  resp_ready,
    output req0_ready, req1_ready, resp_valid, resp_id, resp_data
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// One eBPF-style ALU shared by two requesters, with a single-entry result register.
// Handshake: a transfer happens on any channel when its valid and ready are high at a rising edge.
module alu_share_arbiter #(
  parameter bit RR = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_share_arbiter_if.slave  bus,
  output logic                o_dbg_full
);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  state_t      r_state;
  logic        r_last;
  logic        r_id;
  logic [63:0] r_data;

  logic        w_accept;
  logic        w_grant;
  logic        w_xfer;
  logic [2:0]  w_op;
  logic        w_alu32;
  logic [63:0] w_a;
  logic [63:0] w_b;
  logic [31:0] w_r32;
  logic [63:0] w_r64;
  logic [63:0] w_result;

  // Accepting while FULL is only allowed when the held result drains this same edge.
  always_comb begin
    w_accept = (r_state == S_EMPTY) || bus.resp_ready;
    if (bus.req0_valid && bus.req1_valid) w_grant = RR ? ~r_last : 1'b0;
    else                                  w_grant = bus.req1_valid;
    w_xfer = rst_n && w_accept && (bus.req0_valid || bus.req1_valid);
  end

  assign bus.req0_ready = rst_n && w_accept && bus.req0_valid && !w_grant;
  assign bus.req1_ready = rst_n && w_accept && bus.req1_valid &&  w_grant;

  assign w_op    = w_grant ? bus.req1_op    : bus.req0_op;
  assign w_alu32 = w_grant ? bus.req1_alu32 : bus.req0_alu32;
  assign w_a     = w_grant ? bus.req1_a     : bus.req0_a;
  assign w_b     = w_grant ? bus.req1_b     : bus.req0_b;

  always_comb begin
    w_r32 = '0;
    case (w_op)
      3'd0: w_r32 = w_a[31:0] & w_b[31:0];
      3'd1: w_r32 = w_a[31:0] | w_b[31:0];
      3'd2: w_r32 = w_a[31:0] ^ w_b[31:0];
      3'd3: w_r32 = w_a[31:0] + w_b[31:0];
      3'd4: w_r32 = w_a[31:0] - w_b[31:0];
      3'd5: w_r32 = w_a[31:0] << w_b[4:0];
      3'd6: w_r32 = w_a[31:0] >> w_b[4:0];
      default: w_r32 = $unsigned($signed(w_a[31:0]) >>> w_b[4:0]);
    endcase
  end

  always_comb begin
    w_r64 = '0;
    case (w_op)
      3'd0: w_r64 = w_a & w_b;
      3'd1: w_r64 = w_a | w_b;
      3'd2: w_r64 = w_a ^ w_b;
      3'd3: w_r64 = w_a + w_b;
      3'd4: w_r64 = w_a - w_b;
      3'd5: w_r64 = w_a << w_b[5:0];
      3'd6: w_r64 = w_a >> w_b[5:0];
      default: w_r64 = $unsigned($signed(w_a) >>> w_b[5:0]);
    endcase
  end

  assign w_result = w_alu32 ? {32'h0, w_r32} : w_r64;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
      r_last  <= 1'b1;
      r_id    <= 1'b0;
      r_data  <= '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_xfer) begin
            r_state <= S_FULL;
            r_data  <= w_result;
            r_id    <= w_grant;
            r_last  <= w_grant;
          end
        end
        default: begin
          if (bus.resp_ready) begin
            if (w_xfer) begin
              r_data <= w_result;
              r_id   <= w_grant;
              r_last <= w_grant;
            end else begin
              r_state <= S_EMPTY;
            end
          end
        end
      endcase
    end
  end

  assign bus.resp_valid = (r_state == S_FULL);
  assign bus.resp_id    = r_id;
  assign bus.resp_data  = r_data;
  assign o_dbg_full     = (r_state == S_FULL);

endmodule
